// File: rtl/clock_set_controller_pkg.sv
// Shared types and constants for the clock time-setting controller.
// Widths and wrap limits match the hour (0..23) and minute (0..59) counters.
package clock_pkg;

   localparam int HR_W  = 5;
   localparam int MIN_W = 7;

   localparam logic [HR_W-1:0]  HOURS_MAX   = HR_W'(23);
   localparam logic [MIN_W-1:0] MINUTES_MAX = MIN_W'(59);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      EDIT_HR  = 2'd1,
      EDIT_MIN = 2'd2,
      COMMIT   = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/clock_set_controller_if.sv
// Button, live-time and commit/display signals between the set controller
// and the rest of the clock. The controller uses the slave modport.
interface clock_set_if;
   import clock_pkg::*;

   logic             btn_mode;
   logic             btn_inc;
   logic [HR_W-1:0]  cur_hours;
   logic [MIN_W-1:0] cur_minutes;
   logic             set_pulse;
   logic [HR_W-1:0]  set_hours_val;
   logic [MIN_W-1:0] set_minutes_val;
   logic             editing;
   logic             blink_hr;
   logic             blink_min;

   modport master (
      output btn_mode, btn_inc, cur_hours, cur_minutes,
      input  set_pulse, set_hours_val, set_minutes_val, editing, blink_hr, blink_min
   );

   modport slave (
      input  btn_mode, btn_inc, cur_hours, cur_minutes,
      output set_pulse, set_hours_val, set_minutes_val, editing, blink_hr, blink_min
   );

endinterface

// File: rtl/clock_set_controller_btn_edge_detect.sv
// Rising-edge detector on an already debounced, synchronised button level.
// The first cycle after reset only primes the history, so a held button is not an event.
module btn_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   logic hist_q, hist_d;
   logic armed_q, armed_d;

   always_comb begin
      hist_d  = btn;
      armed_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         armed_q <= armed_d;
      end
   end

   assign rise = armed_q & btn & ~hist_q;

endmodule

// File: rtl/clock_set_controller.sv
// Sequences user time-setting: edit hours, then minutes, then commit with a
// one-cycle set pulse; abandons the edit after an inactivity timeout.
module clock_set_controller #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int BLINK_HALF     = 250
) (
   input logic        clk,
   input logic        reset,
   clock_set_if.slave bus
);
   import clock_pkg::*;

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int BW = $clog2(BLINK_HALF + 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   logic mode_ev, inc_ev;

   btn_edge_detect u_mode_edge (.clk(clk), .reset(reset), .btn(bus.btn_mode), .rise(mode_ev));
   btn_edge_detect u_inc_edge  (.clk(clk), .reset(reset), .btn(bus.btn_inc),  .rise(inc_ev));

   ctrl_state_t      state_q, state_d;
   logic [HR_W-1:0]  edit_hr_q, edit_hr_d;
   logic [MIN_W-1:0] edit_min_q, edit_min_d;
   logic [TW-1:0]    timeout_q, timeout_d;
   logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
   logic             phase_q, phase_d;
   logic             set_pulse_q, set_pulse_d;
   logic [HR_W-1:0]  set_hours_q, set_hours_d;
   logic [MIN_W-1:0] set_minutes_q, set_minutes_d;
   logic             editing_q, editing_d;
   logic             blink_hr_q, blink_hr_d;
   logic             blink_min_q, blink_min_d;

   always_comb begin
      state_d       = state_q;
      edit_hr_d     = edit_hr_q;
      edit_min_d    = edit_min_q;
      timeout_d     = timeout_q;
      blink_cnt_d   = blink_cnt_q;
      phase_d       = phase_q;
      set_hours_d   = set_hours_q;
      set_minutes_d = set_minutes_q;

      case (state_q)
         RUN: begin
            if (mode_ev) begin
               state_d     = EDIT_HR;
               edit_hr_d   = (bus.cur_hours > HOURS_MAX) ? '0 : bus.cur_hours;
               edit_min_d  = (bus.cur_minutes > MINUTES_MAX) ? '0 : bus.cur_minutes;
               timeout_d   = '0;
               blink_cnt_d = '0;
               phase_d     = 1'b1;
            end
         end

         EDIT_HR, EDIT_MIN: begin
            if (blink_cnt_q == BLINK_LAST) begin
               blink_cnt_d = '0;
               phase_d     = ~phase_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 1'b1;
            end

            // Mode beats increment when both rise together; any event beats expiry.
            if (mode_ev) begin
               timeout_d = '0;
               if (state_q == EDIT_HR) begin
                  state_d = EDIT_MIN;
               end else begin
                  state_d       = COMMIT;
                  set_hours_d   = edit_hr_q;
                  set_minutes_d = edit_min_q;
               end
            end else if (inc_ev) begin
               timeout_d = '0;
               if (state_q == EDIT_HR)
                  edit_hr_d = (edit_hr_q == HOURS_MAX) ? '0 : edit_hr_q + 1'b1;
               else
                  edit_min_d = (edit_min_q == MINUTES_MAX) ? '0 : edit_min_q + 1'b1;
            end else if (timeout_q + 1'b1 == TO_LAST) begin
               state_d   = RUN;
               timeout_d = '0;
            end else begin
               timeout_d = timeout_q + 1'b1;
            end
         end

         COMMIT: begin
            state_d = RUN;
         end

         default: begin
            state_d = RUN;
         end
      endcase

      set_pulse_d = (state_d == COMMIT);
      editing_d   = (state_d == EDIT_HR) || (state_d == EDIT_MIN);
      blink_hr_d  = (state_d == EDIT_HR) && phase_d;
      blink_min_d = (state_d == EDIT_MIN) && phase_d;
   end

   // Outputs are registered from next-state values so they line up with state_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         edit_hr_q     <= '0;
         edit_min_q    <= '0;
         timeout_q     <= '0;
         blink_cnt_q   <= '0;
         phase_q       <= 1'b0;
         set_pulse_q   <= 1'b0;
         set_hours_q   <= '0;
         set_minutes_q <= '0;
         editing_q     <= 1'b0;
         blink_hr_q    <= 1'b0;
         blink_min_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         edit_hr_q     <= edit_hr_d;
         edit_min_q    <= edit_min_d;
         timeout_q     <= timeout_d;
         blink_cnt_q   <= blink_cnt_d;
         phase_q       <= phase_d;
         set_pulse_q   <= set_pulse_d;
         set_hours_q   <= set_hours_d;
         set_minutes_q <= set_minutes_d;
         editing_q     <= editing_d;
         blink_hr_q    <= blink_hr_d;
         blink_min_q   <= blink_min_d;
      end
   end

   assign bus.set_pulse       = set_pulse_q;
   assign bus.set_hours_val   = set_hours_q;
   assign bus.set_minutes_val = set_minutes_q;
   assign bus.editing         = editing_q;
   assign bus.blink_hr        = blink_hr_q;
   assign bus.blink_min       = blink_min_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with hand-computed expectations.
// Uses a short timeout (20) and blink half-period (4) to keep runs small.
module tb_clock_set_controller;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   pulse_cnt;
   int   p0;
   logic [11:0] blink_exp;

   clock_set_if bus ();

   clock_set_controller #(
      .TIMEOUT_CYCLES(20),
      .BLINK_HALF(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial pulse_cnt = 0;
   always @(negedge clk) if (bus.set_pulse === 1'b1) pulse_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic mode, input logic inc, input int cycles);
      bus.btn_mode = mode;
      bus.btn_inc  = inc;
      repeat (cycles) tick();
   endtask

   task automatic pressButton(input logic mode, input logic inc);
      applyStimulus(mode, inc, 1);
      applyStimulus(1'b0, 1'b0, 1);
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      reset           = 1'b1;
      bus.btn_mode    = 1'b0;
      bus.btn_inc     = 1'b0;
      bus.cur_hours   = 5'd0;
      bus.cur_minutes = 7'd0;
      repeat (3) tick();
      checkOutput("rst_set_pulse", int'(bus.set_pulse), 0);
      checkOutput("rst_set_hours", int'(bus.set_hours_val), 0);
      checkOutput("rst_set_min",   int'(bus.set_minutes_val), 0);
      checkOutput("rst_editing",   int'(bus.editing), 0);
      checkOutput("rst_blink",     int'({bus.blink_hr, bus.blink_min}), 0);
      reset = 1'b0;
      tick();

      $display("[TB] commit path 13:45 -> 15:48");
      bus.cur_hours = 5'd13; bus.cur_minutes = 7'd45;
      p0 = pulse_cnt;
      pressButton(1'b1, 1'b0);
      checkOutput("cp_editing_hr", int'(bus.editing), 1);
      checkOutput("cp_blink_hr",   int'(bus.blink_hr), 1);
      bus.cur_hours = 5'd14; bus.cur_minutes = 7'd0;
      pressButton(1'b0, 1'b1);
      pressButton(1'b0, 1'b1);
      pressButton(1'b1, 1'b0);
      checkOutput("cp_editing_min",  int'(bus.editing), 1);
      checkOutput("cp_blink_hr_off", int'(bus.blink_hr), 0);
      repeat (3) pressButton(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("cp_pulse",   int'(bus.set_pulse), 1);
      checkOutput("cp_hours",   int'(bus.set_hours_val), 15);
      checkOutput("cp_minutes", int'(bus.set_minutes_val), 48);
      checkOutput("cp_commit_editing", int'(bus.editing), 0);
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("cp_pulse_drop",  int'(bus.set_pulse), 0);
      checkOutput("cp_hours_hold",  int'(bus.set_hours_val), 15);
      checkOutput("cp_min_hold",    int'(bus.set_minutes_val), 48);
      checkOutput("cp_run_editing", int'(bus.editing), 0);
      checkOutput("cp_pulse_count", pulse_cnt - p0, 1);

      $display("[TB] wrap 23:59 -> 00:00");
      bus.cur_hours = 5'd23; bus.cur_minutes = 7'd59;
      pressButton(1'b1, 1'b0);
      pressButton(1'b0, 1'b1);
      pressButton(1'b1, 1'b0);
      pressButton(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("wrap_pulse",   int'(bus.set_pulse), 1);
      checkOutput("wrap_hours",   int'(bus.set_hours_val), 0);
      checkOutput("wrap_minutes", int'(bus.set_minutes_val), 0);
      applyStimulus(1'b0, 1'b0, 1);

      $display("[TB] out-of-range snapshot 30:70 -> 00:00");
      bus.cur_hours = 5'd30; bus.cur_minutes = 7'd70;
      pressButton(1'b0, 1'b1);
      checkOutput("run_inc_ignored", int'(bus.editing), 0);
      pressButton(1'b1, 1'b0);
      pressButton(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("oor_pulse",   int'(bus.set_pulse), 1);
      checkOutput("oor_hours",   int'(bus.set_hours_val), 0);
      checkOutput("oor_minutes", int'(bus.set_minutes_val), 0);
      applyStimulus(1'b0, 1'b0, 1);

      $display("[TB] timeout after 19 idle cycles");
      bus.cur_hours = 5'd6; bus.cur_minutes = 7'd10;
      p0 = pulse_cnt;
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 18);
      checkOutput("to_still_editing", int'(bus.editing), 1);
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("to_expired",  int'(bus.editing), 0);
      checkOutput("to_no_pulse", pulse_cnt - p0, 0);

      $display("[TB] timeout rescued by increment on cycle 19");
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 18);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("to_rescued", int'(bus.editing), 1);
      checkOutput("to_rescued_hr_state", int'(bus.blink_min), 0);
      applyStimulus(1'b0, 1'b0, 18);
      checkOutput("to_rescued_hold", int'(bus.editing), 1);
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("to_rescued_expire", int'(bus.editing), 0);
      checkOutput("to_rescued_no_pulse", pulse_cnt - p0, 0);

      $display("[TB] simultaneous mode and inc");
      bus.cur_hours = 5'd5; bus.cur_minutes = 7'd30;
      pressButton(1'b1, 1'b0);
      pressButton(1'b0, 1'b1);
      pressButton(1'b0, 1'b1);
      pressButton(1'b1, 1'b1);
      checkOutput("sim_editing", int'(bus.editing), 1);
      checkOutput("sim_not_hr",  int'(bus.blink_hr), 0);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("sim_pulse",   int'(bus.set_pulse), 1);
      checkOutput("sim_hours",   int'(bus.set_hours_val), 7);
      checkOutput("sim_minutes", int'(bus.set_minutes_val), 30);
      applyStimulus(1'b0, 1'b0, 1);

      $display("[TB] blink pattern and held increment");
      bus.cur_hours = 5'd10; bus.cur_minutes = 7'd0;
      blink_exp = 12'b1111_0000_1111;
      applyStimulus(1'b1, 1'b0, 1);
      bus.btn_mode = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) tick();
         checkOutput($sformatf("blink_hr_%0d", i), int'(bus.blink_hr), int'(blink_exp[11-i]));
         checkOutput($sformatf("blink_min_%0d", i), int'(bus.blink_min), 0);
      end
      applyStimulus(1'b0, 1'b1, 10);
      applyStimulus(1'b0, 1'b0, 1);
      pressButton(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("hold_pulse",   int'(bus.set_pulse), 1);
      checkOutput("hold_hours",   int'(bus.set_hours_val), 11);
      checkOutput("hold_minutes", int'(bus.set_minutes_val), 0);
      applyStimulus(1'b0, 1'b0, 1);

      $display("[TB] reset during commit");
      bus.cur_hours = 5'd8; bus.cur_minutes = 7'd20;
      pressButton(1'b1, 1'b0);
      pressButton(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("mr_pulse_before", int'(bus.set_pulse), 1);
      #1 reset = 1'b1;
      #1;
      checkOutput("mr_pulse_async", int'(bus.set_pulse), 0);
      checkOutput("mr_hours_clear", int'(bus.set_hours_val), 0);
      checkOutput("mr_editing",     int'(bus.editing), 0);
      tick();
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 3);
      checkOutput("mr_held_mode_no_edit", int'(bus.editing), 0);
      applyStimulus(1'b0, 1'b0, 1);
      pressButton(1'b1, 1'b0);
      checkOutput("mr_fresh_press_edit", int'(bus.editing), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
